exception_unit: RTL and testbench

//  MEM-stage exception/interrupt arbiter; sits directly upstream of cp0_reg.

---
 rtl/exception_unit_pkg.sv | 33 +++
 rtl/exception_unit_prio_enc.sv | 41 ++++
 rtl/exception_unit.sv | 113 +++++++++++
 tb/tb_exception_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/exception_unit_pkg.sv
// Shared constants for the MEM-stage exception unit: exception codes, flag
// bit positions, CP0 register addresses and FSM state encodings.
package exception_unit_pkg;

  localparam logic [4:0] EXC_INT = 5'h00;
  localparam logic [4:0] EXC_SYS = 5'h08;
  localparam logic [4:0] EXC_RI  = 5'h0a;
  localparam logic [4:0] EXC_OV  = 5'h0c;
  localparam logic [4:0] EXC_TR  = 5'h0d;

  localparam int FLAG_SYSCALL = 0;
  localparam int FLAG_TRAP    = 1;
  localparam int FLAG_INV     = 2;
  localparam int FLAG_OV      = 3;
  localparam int FLAG_ERET    = 4;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FLUSH = 2'b01,
    ST_DRAIN = 2'b10
  } exc_state_e;

  // Software may only write Cause.IP[1:0] and bits 23:22; hardware owns the rest.
  function automatic logic [31:0] merge_cause(input logic [31:0] cur,
                                              input logic [31:0] wr);
    merge_cause = {cur[31:24], wr[23:22], cur[21:10], wr[9:8], cur[7:0]};
  endfunction

endpackage

// File: rtl/exception_unit_prio_enc.sv
// Combinational priority encoder: picks the winning exception/interrupt for
// the MEM instruction and reports whether it is a plain ERET.
module exc_prio_enc
  import exception_unit_pkg::*;
(
  input  logic [4:0] flags,
  input  logic       int_pending,
  input  logic       valid,
  output logic       exc_event,
  output logic [4:0] code,
  output logic       is_eret
);

  always_comb begin
    exc_event = 1'b0;
    code      = EXC_INT;
    is_eret   = 1'b0;
    if (valid) begin
      if (int_pending) begin
        exc_event = 1'b1;
        code      = EXC_INT;
      end else if (flags[FLAG_INV]) begin
        exc_event = 1'b1;
        code      = EXC_RI;
      end else if (flags[FLAG_SYSCALL]) begin
        exc_event = 1'b1;
        code      = EXC_SYS;
      end else if (flags[FLAG_TRAP]) begin
        exc_event = 1'b1;
        code      = EXC_TR;
      end else if (flags[FLAG_OV]) begin
        exc_event = 1'b1;
        code      = EXC_OV;
      end else if (flags[FLAG_ERET]) begin
        exc_event = 1'b1;
        is_eret   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/exception_unit.sv
// MEM-stage exception/interrupt arbiter: forwards WB CP0 writes, picks the
// winning event, then issues a registered flush plus one-cycle CP0 commit.
module exception_unit
  import exception_unit_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
  parameter int          DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_in_delay_i,
  input  logic [4:0]  mem_exc_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_wdata_i,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        exc_we_o,
  output logic [4:0]  exc_code_o,
  output logic [31:0] exc_epc_o,
  output logic        exc_bd_o,
  output logic        exc_eret_o,
  output logic        busy_o
);

  localparam logic [2:0] DRAIN_LAST = 3'(DRAIN_CYCLES - 1);

  logic [31:0] eff_status;
  logic [31:0] eff_cause;
  logic [31:0] eff_epc;
  logic        int_pending;
  logic        det_event;
  logic        det_eret;
  logic [4:0]  det_code;
  logic        take;
  logic [2:0]  drain_cnt;
  logic        unused_cp0_bits;

  exc_state_e state, next_state;

  assign eff_status = (wb_cp0_we_i && wb_cp0_waddr_i == CP0_STATUS) ? wb_cp0_wdata_i : cp0_status_i;
  assign eff_epc    = (wb_cp0_we_i && wb_cp0_waddr_i == CP0_EPC)    ? wb_cp0_wdata_i : cp0_epc_i;
  assign eff_cause  = (wb_cp0_we_i && wb_cp0_waddr_i == CP0_CAUSE)
                      ? merge_cause(cp0_cause_i, wb_cp0_wdata_i) : cp0_cause_i;

  assign int_pending = (|(eff_status[15:8] & eff_cause[15:8])) && eff_status[0] && !eff_status[1];

  assign unused_cp0_bits = ^{eff_status[31:16], eff_status[7:2], eff_cause[31:16], eff_cause[7:0]};

  exc_prio_enc u_prio (
    .flags       (mem_exc_i),
    .int_pending (int_pending),
    .valid       (mem_valid_i),
    .exc_event   (det_event),
    .code        (det_code),
    .is_eret     (det_eret)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    take       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (det_event) begin
          next_state = ST_FLUSH;
          take       = 1'b1;
        end
      end
      ST_FLUSH: next_state = ST_DRAIN;
      ST_DRAIN: if (drain_cnt == DRAIN_LAST) next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || state != ST_DRAIN) drain_cnt <= 3'd0;
    else                             drain_cnt <= drain_cnt + 3'd1;
  end

  // Payload is captured only on the detection edge so every output falls back to 0 after one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n || !take) begin
      flush_o    <= 1'b0;
      exc_we_o   <= 1'b0;
      new_pc_o   <= 32'd0;
      exc_code_o <= 5'd0;
      exc_epc_o  <= 32'd0;
      exc_bd_o   <= 1'b0;
      exc_eret_o <= 1'b0;
    end else begin
      flush_o    <= 1'b1;
      exc_we_o   <= 1'b1;
      new_pc_o   <= det_eret ? eff_epc : EXC_VECTOR;
      exc_code_o <= det_eret ? 5'd0 : det_code;
      exc_epc_o  <= det_eret ? 32'd0 : (mem_in_delay_i ? mem_pc_i - 32'd4 : mem_pc_i);
      exc_bd_o   <= mem_in_delay_i && !det_eret;
      exc_eret_o <= det_eret;
    end
  end

  assign busy_o = (state != ST_IDLE);

endmodule

// File: tb/tb_exception_unit.sv
// Directed bench for exception_unit: a table of single-event vectors plus
// hand-written sequences for DRAIN suppression and reset during FLUSH/DRAIN.
module tb_exception_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid_i;
  logic [31:0] mem_pc_i;
  logic        mem_in_delay_i;
  logic [4:0]  mem_exc_i;
  logic [31:0] cp0_status_i;
  logic [31:0] cp0_cause_i;
  logic [31:0] cp0_epc_i;
  logic        wb_cp0_we_i;
  logic [4:0]  wb_cp0_waddr_i;
  logic [31:0] wb_cp0_wdata_i;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        exc_we_o;
  logic [4:0]  exc_code_o;
  logic [31:0] exc_epc_o;
  logic        exc_bd_o;
  logic        exc_eret_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exception_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_valid_i    (mem_valid_i),
    .mem_pc_i       (mem_pc_i),
    .mem_in_delay_i (mem_in_delay_i),
    .mem_exc_i      (mem_exc_i),
    .cp0_status_i   (cp0_status_i),
    .cp0_cause_i    (cp0_cause_i),
    .cp0_epc_i      (cp0_epc_i),
    .wb_cp0_we_i    (wb_cp0_we_i),
    .wb_cp0_waddr_i (wb_cp0_waddr_i),
    .wb_cp0_wdata_i (wb_cp0_wdata_i),
    .flush_o        (flush_o),
    .new_pc_o       (new_pc_o),
    .exc_we_o       (exc_we_o),
    .exc_code_o     (exc_code_o),
    .exc_epc_o      (exc_epc_o),
    .exc_bd_o       (exc_bd_o),
    .exc_eret_o     (exc_eret_o),
    .busy_o         (busy_o)
  );

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic        delay;
    logic [4:0]  exc;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        flush;
    logic [4:0]  code;
    logic [31:0] xepc;
    logic        bd;
    logic        eret;
    logic [31:0] npc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic v, input logic [31:0] pc, input logic d, input logic [4:0] exc,
                              input logic [31:0] st, input logic [31:0] ca, input logic [31:0] ep,
                              input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic fl, input logic [4:0] code, input logic [31:0] xepc,
                              input logic bd, input logic er, input logic [31:0] npc);
    vec_t r;
    r.valid = v;  r.pc = pc;  r.delay = d;  r.exc = exc;
    r.status = st; r.cause = ca; r.epc = ep;
    r.we = we; r.waddr = wa; r.wdata = wd;
    r.flush = fl; r.code = code; r.xepc = xepc; r.bd = bd; r.eret = er; r.npc = npc;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_quiet();
    mem_valid_i = 1'b0; mem_pc_i = 32'd0; mem_in_delay_i = 1'b0; mem_exc_i = 5'd0;
    cp0_status_i = 32'd0; cp0_cause_i = 32'd0; cp0_epc_i = 32'd0;
    wb_cp0_we_i = 1'b0; wb_cp0_waddr_i = 5'd0; wb_cp0_wdata_i = 32'd0;
  endtask

  task automatic apply_stimulus(input vec_t v);
    @(negedge clk);
    mem_valid_i = v.valid; mem_pc_i = v.pc; mem_in_delay_i = v.delay; mem_exc_i = v.exc;
    cp0_status_i = v.status; cp0_cause_i = v.cause; cp0_epc_i = v.epc;
    wb_cp0_we_i = v.we; wb_cp0_waddr_i = v.waddr; wb_cp0_wdata_i = v.wdata;
    @(posedge clk);
    #1;
    set_quiet();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " flush"}, 32'(flush_o), 32'd0);
    check({tag, " we"},    32'(exc_we_o), 32'd0);
    check({tag, " busy"},  32'(busy_o), 32'd0);
    check({tag, " npc"},   new_pc_o, 32'd0);
    check({tag, " code"},  32'(exc_code_o), 32'd0);
    check({tag, " epc"},   exc_epc_o, 32'd0);
    check({tag, " bd"},    32'(exc_bd_o), 32'd0);
    check({tag, " eret"},  32'(exc_eret_o), 32'd0);
  endtask

  task automatic check_output(input string tag, input vec_t v);
    check({tag, " flush"}, 32'(flush_o), 32'(v.flush));
    check({tag, " we"},    32'(exc_we_o), 32'(v.flush));
    check({tag, " busy"},  32'(busy_o), 32'(v.flush));
    if (v.flush) begin
      check({tag, " code"}, 32'(exc_code_o), 32'(v.code));
      check({tag, " bd"},   32'(exc_bd_o), 32'(v.bd));
      check({tag, " eret"}, 32'(exc_eret_o), 32'(v.eret));
      check({tag, " npc"},  new_pc_o, v.npc);
      if (!v.eret) check({tag, " epc"}, exc_epc_o, v.xepc);
    end
  endtask

  // After a flush: two DRAIN cycles with outputs quiet and busy high, then IDLE.
  task automatic check_drain(input string tag);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check($sformatf("%s drain%0d flush", tag, i), 32'(flush_o), 32'd0);
      check($sformatf("%s drain%0d we", tag, i), 32'(exc_we_o), 32'd0);
      check($sformatf("%s drain%0d busy", tag, i), 32'(busy_o), 32'd1);
    end
    @(posedge clk); #1;
    check({tag, " idle busy"}, 32'(busy_o), 32'd0);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy_o && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy_o) check({tag, " idle timeout"}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    vec_t v;
    int flushes;
    set_quiet();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");

    @(negedge clk);
    rst_n = 1'b1;

    //            valid pc           dly exc       status        cause         epc          we wa     wdata         fl code   xepc          bd er npc
    vecs.push_back(mk(1, 32'h100,      0, 5'b00001, 32'h0,        32'h0,        32'h0,       0, 5'd0,  32'h0,        1, 5'h08, 32'h100,      0, 0, 32'h20));
    vecs.push_back(mk(1, 32'h204,      1, 5'b01000, 32'h0,        32'h0,        32'h0,       0, 5'd0,  32'h0,        1, 5'h0c, 32'h200,      1, 0, 32'h20));
    vecs.push_back(mk(1, 32'h300,      0, 5'b00100, 32'h401,      32'h400,      32'h0,       0, 5'd0,  32'h0,        1, 5'h00, 32'h300,      0, 0, 32'h20));
    vecs.push_back(mk(1, 32'h300,      0, 5'b00100, 32'h403,      32'h400,      32'h0,       0, 5'd0,  32'h0,        1, 5'h0a, 32'h300,      0, 0, 32'h20));
    vecs.push_back(mk(1, 32'h500,      1, 5'b10000, 32'h0,        32'h0,        32'h400,     1, 5'd14, 32'h800,      1, 5'h00, 32'h0,        0, 1, 32'h800));
    vecs.push_back(mk(1, 32'h504,      0, 5'b10000, 32'h0,        32'h0,        32'h1234,    1, 5'd12, 32'h0,        1, 5'h00, 32'h0,        0, 1, 32'h1234));
    vecs.push_back(mk(1, 32'h600,      0, 5'b00010, 32'h0,        32'h0,        32'h0,       0, 5'd0,  32'h0,        1, 5'h0d, 32'h600,      0, 0, 32'h20));
    vecs.push_back(mk(1, 32'h610,      0, 5'b01011, 32'h0,        32'h0,        32'h0,       0, 5'd0,  32'h0,        1, 5'h08, 32'h610,      0, 0, 32'h20));
    vecs.push_back(mk(1, 32'h0,        1, 5'b00010, 32'h0,        32'h0,        32'h0,       0, 5'd0,  32'h0,        1, 5'h0d, 32'hFFFF_FFFC, 1, 0, 32'h20));
    vecs.push_back(mk(1, 32'h700,      0, 5'b00000, 32'h0,        32'h100,      32'h0,       1, 5'd12, 32'h101,      1, 5'h00, 32'h700,      0, 0, 32'h20));
    vecs.push_back(mk(1, 32'h710,      0, 5'b00000, 32'h201,      32'h0,        32'h0,       1, 5'd13, 32'h200,      1, 5'h00, 32'h710,      0, 0, 32'h20));
    vecs.push_back(mk(1, 32'h720,      0, 5'b00001, 32'h401,      32'h0,        32'h0,       1, 5'd13, 32'h400,      1, 5'h08, 32'h720,      0, 0, 32'h20));
    vecs.push_back(mk(0, 32'h800,      0, 5'b00001, 32'h0,        32'h0,        32'h0,       0, 5'd0,  32'h0,        0, 5'h00, 32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(0, 32'h804,      0, 5'b00000, 32'h401,      32'h400,      32'h0,       0, 5'd0,  32'h0,        0, 5'h00, 32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(1, 32'h808,      0, 5'b10001, 32'h0,        32'h0,        32'h900,     0, 5'd0,  32'h0,        1, 5'h08, 32'h808,      0, 0, 32'h20));
    vecs.push_back(mk(1, 32'h80c,      0, 5'b10000, 32'h401,      32'h400,      32'h900,     0, 5'd0,  32'h0,        1, 5'h00, 32'h80c,      0, 0, 32'h20));
    vecs.push_back(mk(1, 32'h810,      0, 5'b00000, 32'h400,      32'h400,      32'h0,       0, 5'd0,  32'h0,        0, 5'h00, 32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(1, 32'h814,      1, 5'b00001, 32'h2,        32'h0,        32'h0,       0, 5'd0,  32'h0,        1, 5'h08, 32'h810,      1, 0, 32'h20));

    foreach (vecs[i]) begin
      string tag = $sformatf("vec%0d", i);
      wait_idle(tag);
      apply_stimulus(vecs[i]);
      check_output(tag, vecs[i]);
      if (vecs[i].flush) check_drain(tag);
    end

    // Trap held from the cycle after a syscall: suppressed through DRAIN, taken once IDLE.
    wait_idle("seq5");
    v = mk(1, 32'h100, 0, 5'b00001, 32'h0, 32'h0, 32'h0, 0, 5'd0, 32'h0, 1, 5'h08, 32'h100, 0, 0, 32'h20);
    apply_stimulus(v);
    check_output("seq5 first", v);
    mem_valid_i = 1'b1; mem_pc_i = 32'h104; mem_exc_i = 5'b00010;
    flushes = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (flush_o) flushes++;
    end
    check("seq5 suppressed flushes", 32'(flushes), 32'd0);
    @(posedge clk); #1;
    set_quiet();
    check("seq5 second flush", 32'(flush_o), 32'd1);
    check("seq5 second code", 32'(exc_code_o), 32'h0d);
    check("seq5 second epc", exc_epc_o, 32'h104);
    check_drain("seq5 second");

    // Reset asserted during the FLUSH cycle, then normal operation.
    wait_idle("seq6");
    apply_stimulus(v);
    check_output("seq6 pre", v);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_all_zero("seq6 reset");
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(v);
    check_output("seq6 post", v);
    check_drain("seq6 post");

    // Reset asserted mid-DRAIN returns straight to IDLE and accepts a new event.
    apply_stimulus(v);
    @(posedge clk); #1;
    check("seq7 in drain", 32'(busy_o), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_all_zero("seq7 reset");
    @(negedge clk);
    rst_n = 1'b1;
    v = mk(1, 32'h3000, 1, 5'b01000, 32'h0, 32'h0, 32'h0, 0, 5'd0, 32'h0, 1, 5'h0c, 32'h2FFC, 1, 0, 32'h20);
    apply_stimulus(v);
    check_output("seq7 post", v);

    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
